// File: rtl/K_cpu_pkg.sv
// Shared register-file writeback types: widths, the zero register and the writeback entry.
// No logic; constants and types only.
// Consumers size their ports from these so ALU, load and writeback paths agree.
package K_cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/K_wb_fifo.sv
// Small synchronous FIFO of writeback entries with per-entry valid/rd taps for hazard compare.
// Latency: a pushed entry is visible at the head after one edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module K_wb_fifo
    import K_cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              push,
    input  wb_entry_t                         push_dat,
    input  logic                              pop,
    output wb_entry_t                         head_dat,
    output logic                              full,
    output logic                              empty,
    output logic [$clog2(DEPTH+1)-1:0]        count,
    output logic [DEPTH-1:0]                  entry_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0]      entry_rd
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == ($clog2(DEPTH+1))'(DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr            <= wr_ptr + 1'b1;
                entry_vld[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr            <= rd_ptr + 1'b1;
                entry_vld[rd_ptr] <= 1'b0;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/k_writeback_unit.sv
// Merges ALU results (FIFO) and load returns (one-entry hold, priority) onto the register-file write port.
// Latency: handshake at edge N, write visible after edge N+1; writes to register 0 are squashed.
// Backpressure: alu_ready while FIFO not full, ld_ready while hold empty; both low in reset.
module k_writeback_unit
    import K_cpu_pkg::wb_entry_t;
    import K_cpu_pkg::REG_ZERO;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               alu_valid,
    output logic                               alu_ready,
    input  logic [ADDR_W-1:0]                  alu_rd,
    input  logic [DATA_W-1:0]                  alu_data,
    input  logic                               ld_valid,
    output logic                               ld_ready,
    input  logic [ADDR_W-1:0]                  ld_rd,
    input  logic [DATA_W-1:0]                  ld_data,
    output logic [ADDR_W-1:0]                  rd,
    output logic [DATA_W-1:0]                  K_write_data,
    output logic                               K_Regwrite,
    input  logic [ADDR_W-1:0]                  query_rs,
    input  logic [ADDR_W-1:0]                  query_rt,
    output logic                               rs_pending,
    output logic                               rt_pending,
    output logic [$clog2(FIFO_DEPTH+2)-1:0]    pend_count
);

    localparam int PEND_W = $clog2(FIFO_DEPTH+2);
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1);

    wb_entry_t                         alu_entry;
    wb_entry_t                         fifo_head;
    logic                              fifo_full;
    logic                              fifo_empty;
    logic [CNT_W-1:0]                  fifo_count;
    logic [FIFO_DEPTH-1:0]             fifo_vld;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] fifo_rd;

    wb_entry_t   ld_hold;
    logic        ld_full;
    logic        alu_push;
    logic        ld_push;
    logic        fifo_pop;
    wb_entry_t   sel_dat;
    logic        sel_vld;
    logic        we_next;
    logic [PEND_W-1:0] pend_next;
    logic        rs_hit;
    logic        rt_hit;

    assign alu_entry = '{rd: alu_rd, data: alu_data};
    assign alu_ready = !reset && !fifo_full;
    assign ld_ready  = !reset && !ld_full;
    assign alu_push  = alu_valid && alu_ready;
    assign ld_push   = ld_valid && ld_ready;
    // The hold register wins the slot; the FIFO only drains when no load is parked.
    assign fifo_pop  = !ld_full && !fifo_empty;

    K_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (alu_push),
        .push_dat  (alu_entry),
        .pop       (fifo_pop),
        .head_dat  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .entry_vld (fifo_vld),
        .entry_rd  (fifo_rd)
    );

    always_comb begin
        sel_vld = ld_full || !fifo_empty;
        sel_dat = ld_full ? ld_hold : fifo_head;
        we_next = sel_vld && (sel_dat.rd != REG_ZERO);
        // ld_ready is low while the hold is full, so a load push always lands in an empty hold.
        pend_next = PEND_W'(fifo_count) + PEND_W'(alu_push) - PEND_W'(fifo_pop)
                  + PEND_W'(ld_push) + PEND_W'(we_next);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ld_full      <= 1'b0;
            ld_hold      <= '0;
            K_Regwrite   <= 1'b0;
            rd           <= '0;
            K_write_data <= '0;
            pend_count   <= '0;
        end else begin
            ld_full <= ld_push;
            if (ld_push) begin
                ld_hold <= '{rd: ld_rd, data: ld_data};
            end
            K_Regwrite   <= we_next;
            rd           <= we_next ? sel_dat.rd   : '0;
            K_write_data <= we_next ? sel_dat.data : '0;
            pend_count   <= pend_next;
        end
    end

    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (fifo_vld[i] && fifo_rd[i] == query_rs) rs_hit = 1'b1;
            if (fifo_vld[i] && fifo_rd[i] == query_rt) rt_hit = 1'b1;
        end
        if (ld_full && ld_hold.rd == query_rs) rs_hit = 1'b1;
        if (ld_full && ld_hold.rd == query_rt) rt_hit = 1'b1;
        if (K_Regwrite && rd == query_rs)      rs_hit = 1'b1;
        if (K_Regwrite && rd == query_rt)      rt_hit = 1'b1;
    end

    assign rs_pending = rs_hit && (query_rs != REG_ZERO);
    assign rt_pending = rt_hit && (query_rt != REG_ZERO);

endmodule

// File: tb/tb_k_writeback_unit.sv
// Self-checking bench for k_writeback_unit: directed scenarios plus random traffic against a queue model.
module tb_k_writeback_unit;

    localparam int DEPTH = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rd;
    logic [31:0] K_write_data;
    logic        K_Regwrite;
    logic [4:0]  query_rs;
    logic [4:0]  query_rt;
    logic        rs_pending;
    logic        rt_pending;
    logic [1:0]  pend_count;

    k_writeback_unit #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .rd           (rd),
        .K_write_data (K_write_data),
        .K_Regwrite   (K_Regwrite),
        .query_rs     (query_rs),
        .query_rt     (query_rt),
        .rs_pending   (rs_pending),
        .rt_pending   (rt_pending),
        .pend_count   (pend_count)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of ALU results, one parked load, and the last write presented.
    ent_t        mq[$];
    ent_t        m_ld;
    bit          m_ldf;
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_dat;
    bit          alu_acc;
    bit          ld_acc;
    ent_t        alu_src[$];
    int          max_fifo_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_pending(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
        if (m_ldf && m_ld.rd == q) return 1'b1;
        if (m_we && m_rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge();
        bit   acc_a, acc_l, pv;
        ent_t pe;
        if (reset) begin
            mq.delete();
            m_ldf = 0; m_we = 0; m_rd = '0; m_dat = '0;
            alu_acc = 0; ld_acc = 0;
            return;
        end
        acc_a = alu_valid && (mq.size() < DEPTH);
        acc_l = ld_valid && !m_ldf;
        pv = 0;
        if (m_ldf) begin
            pv = 1; pe = m_ld; m_ldf = 0;
        end else if (mq.size() > 0) begin
            pv = 1; pe = mq.pop_front();
        end
        if (pv && pe.rd != 5'd0) begin
            m_we = 1; m_rd = pe.rd; m_dat = pe.data;
        end else begin
            m_we = 0; m_rd = '0; m_dat = '0;
        end
        if (acc_a) mq.push_back('{rd: alu_rd, data: alu_data});
        if (acc_l) begin
            m_ld = '{rd: ld_rd, data: ld_data};
            m_ldf = 1;
        end
        if (mq.size() > max_fifo_seen) max_fifo_seen = mq.size();
        alu_acc = acc_a;
        ld_acc  = acc_l;
    endtask

    task automatic compare_all();
        check("alu_ready",  alu_ready,  32'(!reset && mq.size() < DEPTH));
        check("ld_ready",   ld_ready,   32'(!reset && !m_ldf));
        check("regwrite",   K_Regwrite, 32'(m_we));
        check("rd",         rd,         32'(m_rd));
        check("wdata",      K_write_data, m_dat);
        check("pend_count", pend_count, 32'(mq.size() + int'(m_ldf) + int'(m_we)));
        check("rs_pending", rs_pending, 32'(model_pending(query_rs)));
        check("rt_pending", rt_pending, 32'(model_pending(query_rt)));
    endtask

    // Inputs applied just after a rising edge; outputs checked on the falling edge.
    task automatic tick(input bit rst, input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [31:0] ldat,
                        input logic [4:0] qs, input logic [4:0] qt);
        reset = rst; alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ldat;
        query_rs = qs; query_rt = qt;
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n, input logic [4:0] qs);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0, qs, 0);
    endtask

    // Offer alu_src in order, optionally with a load offered every cycle, until drained or budget out.
    task automatic drain(input int budget, input bit ld_cont, input logic [4:0] lrd);
        int n = 0;
        while (alu_src.size() > 0 && n < budget) begin
            tick(0, 1, alu_src[0].rd, alu_src[0].data, ld_cont, lrd, 32'h1000 + 32'(n),
                 alu_src[0].rd, lrd);
            if (alu_acc) void'(alu_src.pop_front());
            n++;
        end
        check("drain_left", 32'(alu_src.size()), 32'd0);
        alu_src.delete();
    endtask

    initial begin
        reset = 1; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; query_rs = 0; query_rt = 0;
        max_fifo_seen = 0;
        @(posedge clock);
        @(posedge clock);
        model_edge();
        #1;
        tick(1, 1, 5'd3, 32'd1, 1, 5'd4, 32'd2, 5'd3, 5'd4);
        idle(1, 0);

        // Single ALU result on an idle unit.
        tick(0, 1, 5'd6, 32'd300, 0, 0, 0, 5'd6, 0);
        check("t1_pend_a", pend_count, 32'd1);
        check("t1_rs_a",   rs_pending, 32'd1);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd6, 0);
        check("t1_we",    K_Regwrite,   32'd1);
        check("t1_rd",    rd,           32'd6);
        check("t1_data",  K_write_data, 32'd300);
        check("t1_rs_b",  rs_pending,   32'd1);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd6, 0);
        check("t1_pend_z", pend_count, 32'd0);
        check("t1_rs_z",   rs_pending, 32'd0);

        // Load and ALU in the same cycle: load writes first.
        tick(0, 1, 5'd5, 32'd7, 1, 5'd4, 32'hAAAA, 5'd4, 5'd5);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd5);
        check("t2_rd_first",  rd, 32'd4);
        check("t2_dat_first", K_write_data, 32'hAAAA);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd4, 5'd5);
        check("t2_rd_second", rd, 32'd5);
        check("t2_dat_second", K_write_data, 32'd7);
        idle(2, 0);

        // Three ALU results against continuous load traffic.
        for (int i = 1; i <= 3; i++) alu_src.push_back('{rd: 5'(i), data: 32'(i * 11)});
        drain(20, 1, 5'd9);
        idle(4, 0);

        // Destination zero is consumed silently.
        tick(0, 1, 5'd0, 32'hFFFF, 0, 0, 0, 5'd0, 5'd0);
        check("t4_rs0", rs_pending, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
        check("t4_we0",  K_Regwrite, 32'd0);
        check("t4_pend", pend_count, 32'd0);
        idle(1, 0);

        // Ten back-to-back ALU results exercising pointer wrap.
        max_fifo_seen = 0;
        for (int i = 1; i <= 10; i++) alu_src.push_back('{rd: 5'(i), data: 32'(100 + i)});
        drain(40, 0, 5'd0);
        idle(3, 0);
        check("t5_fifo_max", 32'(max_fifo_seen <= DEPTH), 32'd1);

        // Reset with writes in flight.
        tick(0, 1, 5'd7, 32'd70, 1, 5'd8, 32'd80, 5'd7, 5'd8);
        tick(0, 1, 5'd10, 32'd90, 0, 0, 0, 5'd7, 5'd10);
        tick(1, 0, 0, 0, 0, 0, 0, 5'd7, 5'd10);
        check("t6_we",   K_Regwrite, 32'd0);
        check("t6_pend", pend_count, 32'd0);
        check("t6_rs",   rs_pending, 32'd0);
        check("t6_rt",   rt_pending, 32'd0);
        tick(0, 0, 0, 0, 0, 0, 0, 5'd7, 5'd10);
        check("t6_alu_rdy", alu_ready, 32'd1);
        check("t6_ld_rdy",  ld_ready,  32'd1);

        // Random traffic with a narrow register range to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            tick(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 99) < 40), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/k_writeback_unit.md
Name: K_writeback_unit

Overview:
- Write-side master for the 32x32 register file: merges the ALU result stream and the load-return stream onto the file's single write port (rd, K_write_data, K_Regwrite).
- ALU results are buffered in a small FIFO. Load returns sit in a one-entry holding register and have priority.
- Comparators flag source registers with writes still pending, so the decode stage can stall on RAW/WAW hazards.

Parameters:
DATA_W, 32, result/data width
ADDR_W, 5, register index width
FIFO_DEPTH, 2, ALU FIFO entries; power of 2, >= 2

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted this edge when alu_valid also high
alu_rd  input  ADDR_W  ALU destination register
alu_data  input  DATA_W  ALU result
ld_valid  input  1  load data offered
ld_ready  output  1  load data accepted this edge when ld_valid also high
ld_rd  input  ADDR_W  load destination register
ld_data  input  DATA_W  load data
rd  output  ADDR_W  register-file write index (registered)
K_write_data  output  DATA_W  register-file write data (registered)
K_Regwrite  output  1  register-file write enable (registered)
query_rs  input  ADDR_W  decode source register 1
query_rt  input  ADDR_W  decode source register 2
rs_pending  output  1  write to query_rs still in flight
rt_pending  output  1  write to query_rt still in flight
pend_count  output  clog2(FIFO_DEPTH+2)  valid entries: FIFO + holding register + active output register

Behaviour:
- Reset (sync, active-high): clear FIFO pointers and count, ld_full, rd, K_write_data, K_Regwrite and pend_count to 0. While reset is high, force alu_ready=0 and ld_ready=0. In-flight entries are discarded. Reset mid-stream has the same effect: the next cycle starts empty.
- Ready signals:
  - alu_ready = !fifo_full (no push-through when full).
  - ld_ready = !ld_full (no pass-through).
- Push: an ALU handshake writes {alu_rd, alu_data} at the tail. A load handshake fills the holding register and sets ld_full.
- Selection, evaluated every cycle:
  - If ld_full, pop the holding register.
  - Else if FIFO is non-empty, pop the FIFO head.
  - Else nothing; output register loads K_Regwrite=0, rd=0, K_write_data=0.
- Output register: the popped entry loads {rd, K_write_data} at the edge, with K_Regwrite=1. The register file samples these in the following cycle.
- Latency, idle unit: handshake at edge N, output valid after edge N+1 (2 edges).
- Register 0: an entry with destination 0 is accepted and popped normally, but the output loads K_Regwrite=0, rd=0, K_write_data=0. No write ever reaches register 0.
- Fairness: because ld_ready is low while ld_full, loads take at most every other slot. A waiting ALU head therefore waits at most 1 cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged, wrap-around via pointer modulo FIFO_DEPTH.
- Full FIFO with a pop in the same cycle: alu_ready stays 0 that cycle and the push is refused.
- Pending flags (combinational):
  - rs_pending is 1 when query_rs != 0 and it matches any valid FIFO entry, the holding register, or the output register with K_Regwrite=1.
  - rt_pending is identical for query_rt.
  - Query value 0 always gives 0.
- Ordering: FIFO order within the ALU channel. No ordering guarantee across the ALU and load channels; issue logic must stall on the pending flags to avoid WAW hazards.
- pend_count is registered and updated with every push/pop.

Decomposition:
- Shared package `K_cpu_pkg`: DATA_W, ADDR_W, REG_ZERO=0, and a writeback entry struct {rd, data}.
- One sub-module `K_wb_fifo`: parameterised sync FIFO (push/pop, full/empty, count, per-entry valid and rd exposed for the pending comparators).
- Selection, holding register, output register and comparators live in the top module.

Test Plan:
- ALU result rd=6, data=300 on an idle unit → K_Regwrite=1, rd=6, K_write_data=300 after the 2nd edge; pend_count goes 1 then 0; rs_pending=1 for query_rs=6 until the write cycle completes.
- Load rd=4 (data=0xAAAA) and ALU rd=5 (data=7) in the same cycle → write rd=4 first, then rd=5 in the next slot.
- Three back-to-back ALU pushes (rd 1,2,3) with continuous load traffic (rd 9) → alu_ready deasserts when full, no ALU wait exceeds 1 cycle, writes land in order 1,2,3 interleaved with loads, no data lost.
- ALU rd=0, data=0xFFFF → entry is consumed and K_Regwrite stays 0; query_rs=0 → rs_pending=0.
- FIFO wrap: push/pop 10 consecutive entries (rd 1..10) at full throughput → in-order writes, count never exceeds FIFO_DEPTH, pointers wrap correctly.
- Reset asserted while 2 entries are pending → the following cycle shows K_Regwrite=0, pend_count=0, both pending flags 0; both readys are 1 after reset drops.
